dcf77_encoder: RTL and testbench
================================

Name: dcf77_encoder

Overview:
- Generates a DCF77 time-code pulse stream from BCD date/time; it is the transmit-side counterpart of the DCF77 receiver/decoder.
- Used as a loopback stimulus source for the receiver, and to drive an amplitude-modulation output stage.
- Encodes one 59-bit frame per minute from BCD fields of the same format as the date/time interface.
- Requests the next minute's data through a valid/ready handshake.

Parameters:
CLK_HZ, 12_000_000, clock cycles per second; must be a multiple of 10.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  1 = run transmitter; 0 = idle
dt_valid  in  1  date/time inputs valid for load
dt_ready  out  1  encoder accepts date/time this cycle
minute  in  8  BCD, 2 digits, 00-59
hour  in  8  BCD, 00-23
day  in  8  BCD, 01-31
month  in  8  BCD, 01-12
year  in  8  BCD, 00-99
day_of_week  in  3  1=Mon..7=Sun
cest  in  1  1 = summer time; drives Z1=1, Z2=0 (else Z1=0, Z2=1)
dst_announce  in  1  A1 bit
leap_announce  in  1  A2 bit / leap request (see Optional Feature)
dcf77  out  1  1 = carrier reduced (pulse active)
second_tick  out  1  one-cycle pulse at first cycle of every second
second_count  out  6  current second index 0..59 (0..60 with leap)
underrun  out  1  one-cycle pulse: frame started without new data

Behaviour:
- Reset values: all outputs 0; latched frame registers 0; state IDLE. Reset mid-frame aborts the frame immediately.
- Timing:
  - Prescaler counts 0..CLK_HZ-1; its wrap defines a second boundary.
  - W0 = CLK_HZ/10 cycles, W1 = CLK_HZ/5 cycles.
- States: IDLE -> GAP -> SEND -> GAP ...
- IDLE: outputs 0, counters 0. enable=1 -> GAP at next cycle with second_count=59, prescaler=0.
- GAP (final second of the minute, no pulse):
  - dcf77=0; dt_ready=1 until a handshake occurs.
  - Handshake: dt_valid&&dt_ready -> latch all inputs that cycle; dt_ready=0 from the next cycle.
  - At prescaler wrap -> SEND, second_count=0.
  - If no handshake occurred in GAP: underrun=1 for the first cycle of second 0, and the previously latched data is reused. After reset this is all-zero data.
- SEND:
  - Each second starts with second_tick=1 and dcf77=1 in the same cycle; dcf77 stays 1 for W0 or W1 cycles, selected by the frame bit.
  - Frame bit map, each BCD field sent LSB first, units digit before tens digit:
    - 0: 0.
    - 1-15: 0 (warning bits and call bit not generated).
    - 16: A1. 17: Z1. 18: Z2. 19: A2. 20: 1.
    - 21-27: minute (4+3 bits). 28: P1.
    - 29-34: hour (4+2 bits). 35: P2.
    - 36-41: day (4+2 bits). 42-44: day_of_week. 45-49: month (4+1 bits). 50-57: year (8 bits). 58: P3.
  - P1/P2/P3 are even parity over bits 21-27, 29-34 and 36-57 respectively.
  - After second 58 -> GAP, second_count=59.
- Unused BCD tens bits (e.g. minute[7], hour[7:6]) are ignored. No range checking is done.
- enable=0 in any state: IDLE at the next cycle; dcf77, dt_ready and counters are 0 from then on. A partial frame is not completed.
- Simultaneous dt_valid at the GAP->SEND wrap cycle: the handshake counts and the new data is used for the frame just starting; no underrun.

Optional Feature:
DCF77_ENCODER_LEAP_EN
- Defined:
  - Bit 19 = latched leap_announce.
  - If it is set, the minute has 61 seconds: second 59 carries a 0-bit (W0 pulse), and second 60 is GAP (no pulse, dt_ready active).
  - second_count reaches 60. The latched leap flag applies to the current frame only.
- Not defined:
  - Bit 19 is always 0 and leap_announce is ignored.
  - The minute is always 60 seconds.

Test Plan:
- CLK_HZ=100. Reset with enable=1 -> all outputs 0 while reset=1. First cycle after reset: GAP entered, dt_ready=1, second_count=59, dcf77=0.
- Load minute=8'h37, hour=8'h14, day=8'h25, day_of_week=3, month=8'h12, year=8'h24, cest=0 -> frame checks:
  - bit 0 pulse 10 cycles; bit 18 pulse 20 cycles; bit 20 pulse 20 cycles.
  - bits 21-27 = 1,1,1,0,1,1,0 and P1=1.
  - bits 29-34 = 0,0,1,0,1,0 and P2=0.
  - second 59 no pulse; total minute = 6000 cycles.
- dt_valid held 0 through GAP -> underrun=1 for one cycle at second 0 start; next frame bit-identical to the previous one.
- dt_valid asserted 37 cycles into GAP -> accepted that cycle, dt_ready=0 next cycle, no underrun, new data sent.
- enable dropped 5 cycles into second 30's pulse -> dcf77=0, second_count=0, dt_ready=0 at next cycle. Re-enable -> restart in GAP.
- Leap check, leap_announce=1:
  - With DCF77_ENCODER_LEAP_EN: bit 19 pulse 20 cycles, second 59 pulse 10 cycles, second_count reaches 60, minute = 6100 cycles.
  - Without the macro: bit 19 pulse 10 cycles, minute = 6000 cycles.

Source files
------------

// File: rtl/dcf77_encoder.sv
// DCF77 time-code transmitter: one 59-bit BCD frame per minute, data requested via valid/ready.
// Define DCF77_ENCODER_LEAP_EN to honour leap_announce (61-second minute with bit 19 set).
module dcf77_encoder #(
    parameter int CLK_HZ = 12_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       dt_valid,
    output logic       dt_ready,
    input  logic [7:0] minute,
    input  logic [7:0] hour,
    input  logic [7:0] day,
    input  logic [7:0] month,
    input  logic [7:0] year,
    input  logic [2:0] day_of_week,
    input  logic       cest,
    input  logic       dst_announce,
    input  logic       leap_announce,
    output logic       dcf77,
    output logic       second_tick,
    output logic [5:0] second_count,
    output logic       underrun
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] W0        = PW'(CLK_HZ / 10);
    localparam logic [PW-1:0] W1        = PW'(CLK_HZ / 5);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    function automatic logic even_par(input logic [21:0] v);
        return ^v;
    endfunction

    state_t          r_state;
    logic [PW-1:0]   r_presc;
    logic [5:0]      r_sec;
    logic            r_hs_done;
    logic [6:0]      r_min;
    logic [5:0]      r_hour;
    logic [5:0]      r_day;
    logic [4:0]      r_mon;
    logic [7:0]      r_year;
    logic [2:0]      r_dow;
    logic            r_cest;
    logic            r_a1;
    logic            r_ready;
    logic            r_dcf;
    logic            r_tick;
    logic            r_under;
`ifdef DCF77_ENCODER_LEAP_EN
    logic            r_leap;
    logic            w_leap_n;
`endif

    state_t          w_state_n;
    logic [PW-1:0]   w_presc_n;
    logic [5:0]      w_sec_n;
    logic            w_hs;
    logic            w_hs_done_n;
    logic [6:0]      w_min_n;
    logic [5:0]      w_hour_n;
    logic [5:0]      w_day_n;
    logic [4:0]      w_mon_n;
    logic [7:0]      w_year_n;
    logic [2:0]      w_dow_n;
    logic            w_cest_n;
    logic            w_a1_n;
    logic [63:0]     w_frame;
    logic            w_bit;
    logic            w_ready_n;
    logic            w_dcf_n;
    logic            w_tick_n;
    logic            w_under_n;
    logic            w_unused;

`ifdef DCF77_ENCODER_LEAP_EN
    assign w_unused = ^{minute[7], hour[7:6], day[7:6], month[7:5]};
`else
    assign w_unused = ^{minute[7], hour[7:6], day[7:6], month[7:5], leap_announce};
`endif

    // Next-state, data latch and output decode; outputs are derived from next state so they register cleanly.
    always_comb begin
        w_hs        = dt_valid && r_ready;
        w_state_n   = r_state;
        w_presc_n   = r_presc;
        w_sec_n     = r_sec;
        w_hs_done_n = r_hs_done || w_hs;
        w_min_n     = w_hs ? minute[6:0]  : r_min;
        w_hour_n    = w_hs ? hour[5:0]    : r_hour;
        w_day_n     = w_hs ? day[5:0]     : r_day;
        w_mon_n     = w_hs ? month[4:0]   : r_mon;
        w_year_n    = w_hs ? year         : r_year;
        w_dow_n     = w_hs ? day_of_week  : r_dow;
        w_cest_n    = w_hs ? cest         : r_cest;
        w_a1_n      = w_hs ? dst_announce : r_a1;
`ifdef DCF77_ENCODER_LEAP_EN
        w_leap_n    = w_hs ? leap_announce : r_leap;
`endif
        if (!enable) begin
            w_state_n   = ST_IDLE;
            w_presc_n   = '0;
            w_sec_n     = 6'd0;
            w_hs_done_n = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_n   = ST_GAP;
                    w_presc_n   = '0;
                    w_sec_n     = 6'd59;
                    w_hs_done_n = 1'b0;
                end
                ST_GAP: begin
                    if (r_presc == PRESC_MAX) begin
                        w_state_n = ST_SEND;
                        w_presc_n = '0;
                        w_sec_n   = 6'd0;
                    end else begin
                        w_presc_n = r_presc + PW'(1);
                    end
                end
                ST_SEND: begin
                    if (r_presc == PRESC_MAX) begin
                        w_presc_n = '0;
                        if (r_sec == 6'd58) begin
`ifdef DCF77_ENCODER_LEAP_EN
                            if (r_leap) begin
                                w_sec_n = 6'd59;
                            end else begin
                                w_state_n   = ST_GAP;
                                w_sec_n     = 6'd59;
                                w_hs_done_n = 1'b0;
                            end
`else
                            w_state_n   = ST_GAP;
                            w_sec_n     = 6'd59;
                            w_hs_done_n = 1'b0;
`endif
                        end
`ifdef DCF77_ENCODER_LEAP_EN
                        else if (r_sec == 6'd59) begin
                            // Leap second sent; the flag is consumed so reused data does not repeat it.
                            w_state_n   = ST_GAP;
                            w_sec_n     = 6'd60;
                            w_hs_done_n = 1'b0;
                            w_leap_n    = 1'b0;
                        end
`endif
                        else begin
                            w_sec_n = r_sec + 6'd1;
                        end
                    end else begin
                        w_presc_n = r_presc + PW'(1);
                    end
                end
                default: begin
                    w_state_n = ST_IDLE;
                    w_presc_n = '0;
                    w_sec_n   = 6'd0;
                end
            endcase
        end

        w_frame        = 64'd0;
        w_frame[16]    = w_a1_n;
        w_frame[17]    = w_cest_n;
        w_frame[18]    = ~w_cest_n;
`ifdef DCF77_ENCODER_LEAP_EN
        w_frame[19]    = w_leap_n;
`else
        w_frame[19]    = 1'b0;
`endif
        w_frame[20]    = 1'b1;
        w_frame[27:21] = w_min_n;
        w_frame[28]    = even_par({15'd0, w_min_n});
        w_frame[34:29] = w_hour_n;
        w_frame[35]    = even_par({16'd0, w_hour_n});
        w_frame[41:36] = w_day_n;
        w_frame[44:42] = w_dow_n;
        w_frame[49:45] = w_mon_n;
        w_frame[57:50] = w_year_n;
        w_frame[58]    = even_par({w_day_n, w_dow_n, w_mon_n, w_year_n});
        w_bit          = w_frame[w_sec_n];

        w_ready_n = (w_state_n == ST_GAP) && !w_hs_done_n;
        w_tick_n  = (w_state_n == ST_SEND) && (w_presc_n == '0);
        w_dcf_n   = (w_state_n == ST_SEND) && (w_presc_n < (w_bit ? W1 : W0));
        w_under_n = (r_state == ST_GAP) && (w_state_n == ST_SEND) && !w_hs_done_n;
    end

    // State, counters, latched frame data and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_presc   <= '0;
            r_sec     <= 6'd0;
            r_hs_done <= 1'b0;
            r_min     <= 7'd0;
            r_hour    <= 6'd0;
            r_day     <= 6'd0;
            r_mon     <= 5'd0;
            r_year    <= 8'd0;
            r_dow     <= 3'd0;
            r_cest    <= 1'b0;
            r_a1      <= 1'b0;
            r_ready   <= 1'b0;
            r_dcf     <= 1'b0;
            r_tick    <= 1'b0;
            r_under   <= 1'b0;
`ifdef DCF77_ENCODER_LEAP_EN
            r_leap    <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_n;
            r_presc   <= w_presc_n;
            r_sec     <= w_sec_n;
            r_hs_done <= w_hs_done_n;
            r_min     <= w_min_n;
            r_hour    <= w_hour_n;
            r_day     <= w_day_n;
            r_mon     <= w_mon_n;
            r_year    <= w_year_n;
            r_dow     <= w_dow_n;
            r_cest    <= w_cest_n;
            r_a1      <= w_a1_n;
            r_ready   <= w_ready_n;
            r_dcf     <= w_dcf_n;
            r_tick    <= w_tick_n;
            r_under   <= w_under_n;
`ifdef DCF77_ENCODER_LEAP_EN
            r_leap    <= w_leap_n;
`endif
        end
    end

    assign dt_ready     = r_ready;
    assign dcf77        = r_dcf;
    assign second_tick  = r_tick;
    assign second_count = r_sec;
    assign underrun     = r_under;

endmodule

// File: tb/tb_dcf77_encoder.sv
// Directed bench for dcf77_encoder at CLK_HZ=100 (W0=10, W1=20 cycles, 100-cycle seconds).
module tb_dcf77_encoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       dt_valid;
    logic       dt_ready;
    logic [7:0] minute, hour, day, month, year;
    logic [2:0] day_of_week;
    logic       cest, dst_announce, leap_announce;
    logic       dcf77, second_tick, underrun;
    logic [5:0] second_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int cap_w [0:58];
    logic cap_u0, cap_u1;
    int cap_t0;

    dcf77_encoder #(.CLK_HZ(100)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .dt_valid(dt_valid), .dt_ready(dt_ready),
        .minute(minute), .hour(hour), .day(day), .month(month), .year(year),
        .day_of_week(day_of_week), .cest(cest), .dst_announce(dst_announce),
        .leap_announce(leap_announce),
        .dcf77(dcf77), .second_tick(second_tick), .second_count(second_count),
        .underrun(underrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Hand-encoded frames, index 0 = second 0.
    string fa = {"0000000000000000", "00101", "11101101", "0010100", "101001", "110", "01001", "00100100", "1"};
    string fb = {"0000000000000000", "11001", "10011010", "1100011", "100011", "111", "10010", "10011001", "0"};
    string fl;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic give_up(input string tag);
        checks++;
        errors++;
        $error("FAIL timeout %s: observed no event expected event", tag);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    task automatic wait_tick(input int n);
        bit ok;
        ok = (second_tick === 1'b1) && (int'(second_count) == n);
        for (int i = 0; i < 7000 && !ok; i++) begin
            step();
            ok = (second_tick === 1'b1) && (int'(second_count) == n);
        end
        if (!ok) give_up($sformatf("tick %0d", n));
    endtask

    task automatic wait_count(input int n);
        bit ok;
        ok = (int'(second_count) == n);
        for (int i = 0; i < 7000 && !ok; i++) begin
            step();
            ok = (int'(second_count) == n);
        end
        if (!ok) give_up($sformatf("count %0d", n));
    endtask

    task automatic pulse_width(output int w);
        w = 0;
        while (dcf77 === 1'b1 && w < 500) begin
            w++;
            step();
        end
    endtask

    task automatic capture_frame();
        int w;
        wait_tick(0);
        cap_t0 = cyc;
        cap_u0 = underrun;
        cap_u1 = underrun;
        w = 0;
        while (dcf77 === 1'b1 && w < 500) begin
            w++;
            step();
            if (w == 1) cap_u1 = underrun;
        end
        cap_w[0] = w;
        for (int s = 1; s < 59; s++) begin
            wait_tick(s);
            pulse_width(w);
            cap_w[s] = w;
        end
    endtask

    task automatic check_frame(input string tag, input string exp);
        for (int i = 0; i < 59; i++)
            check($sformatf("%s bit %0d", tag, i), cap_w[i], (exp[i] == 8'h31) ? 32'd20 : 32'd10);
    endtask

    task automatic set_a();
        minute = 8'h37; hour = 8'h14; day = 8'h25; day_of_week = 3'd3;
        month = 8'h12; year = 8'h24; cest = 1'b0; dst_announce = 1'b0;
    endtask

    task automatic set_b();
        minute = 8'h59; hour = 8'h23; day = 8'h31; day_of_week = 3'd7;
        month = 8'h09; year = 8'h99; cest = 1'b1; dst_announce = 1'b1;
    endtask

    initial begin
        int hi, t_prev, w;
        reset = 1'b1; enable = 1'b1; dt_valid = 1'b0; leap_announce = 1'b0;
        set_a();
        repeat (3) step();
        check("reset dcf77", dcf77, 0);
        check("reset dt_ready", dt_ready, 0);
        check("reset second_tick", second_tick, 0);
        check("reset second_count", second_count, 0);
        check("reset underrun", underrun, 0);

        @(negedge clk) reset = 1'b0;
        step();
        check("gap entry dt_ready", dt_ready, 1);
        check("gap entry second_count", second_count, 59);
        check("gap entry dcf77", dcf77, 0);

        dt_valid = 1'b1;
        step();
        check("ready drops after load", dt_ready, 0);
        dt_valid = 1'b0;
        set_b();

        capture_frame();
        check("frame1 underrun", cap_u0, 0);
        check_frame("frame1", fa);
        t_prev = cap_t0;

        wait_count(59);
        check("gap1 dt_ready", dt_ready, 1);
        hi = 0;
        for (int i = 0; i < 200 && int'(second_count) == 59; i++) begin
            hi += int'(dcf77);
            step();
        end
        check("gap1 no pulse", hi, 0);

        capture_frame();
        check("frame2 underrun start", cap_u0, 1);
        check("frame2 underrun one cycle", cap_u1, 0);
        check_frame("frame2 reuse", fa);
        check("minute length", cap_t0 - t_prev, 6000);
        t_prev = cap_t0;

        wait_count(59);
        repeat (37) step();
        dt_valid = 1'b1;
        check("late load ready", dt_ready, 1);
        step();
        check("late load ready drops", dt_ready, 0);
        dt_valid = 1'b0;
        set_a();

        capture_frame();
        check("frame3 underrun", cap_u0, 0);
        check_frame("frame3", fb);
        check("minute length 2", cap_t0 - t_prev, 6000);

        wait_tick(30);
        repeat (5) step();
        check("sec30 pulse active", dcf77, 1);
        enable = 1'b0;
        step();
        check("disable dcf77", dcf77, 0);
        check("disable second_count", second_count, 0);
        check("disable dt_ready", dt_ready, 0);
        repeat (20) step();
        check("idle dt_ready", dt_ready, 0);
        check("idle second_tick", second_tick, 0);

        set_a();
        leap_announce = 1'b1;
        enable = 1'b1;
        step();
        check("restart dt_ready", dt_ready, 1);
        check("restart second_count", second_count, 59);
        dt_valid = 1'b1;
        step();
        dt_valid = 1'b0;
        leap_announce = 1'b0;

        fl = fa;
`ifdef DCF77_ENCODER_LEAP_EN
        fl[19] = 8'h31;
`endif
        capture_frame();
        check_frame("leap frame", fl);
`ifdef DCF77_ENCODER_LEAP_EN
        wait_tick(59);
        pulse_width(w);
        check("leap second 59 pulse", w, 10);
        wait_count(60);
        check("leap gap dt_ready", dt_ready, 1);
        check("leap gap dcf77", dcf77, 0);
        t_prev = cap_t0;
        wait_tick(0);
        check("leap minute length", cyc - t_prev, 6100);
`else
        t_prev = cap_t0;
        wait_tick(0);
        check("no-leap minute length", cyc - t_prev, 6000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
